pe_vector_checker: RTL and testbench
====================================

// Module: pe_vector_checker
// PURPOSE
//  Self-test consumer placed directly downstream of the test-vector source.
//  On each start pulse it captures one vector (inp, par, prop, expected result), computes
//  prop + inp*par with a sequential shift-add MAC and compares the sum with the expected
//  result. It then reports pass/fail per vector and keeps saturating pass/fail tallies
//  for the board LEDs.
// PARAMETERS
//  DATA_WIDTH  8  operand width; prop/expected/mac_out are 2*DATA_WIDTH
//  CNT_WIDTH   4  width of pass_cnt/fail_cnt tallies
// PORTS
//  clk       in   1             clock
//  reset_n   in   1             reset, synchronous, active-low
//  start     in   1             1-cycle request; sampled only in IDLE
//  inp       in   DATA_WIDTH    multiplicand (unsigned)
//  par       in   DATA_WIDTH    multiplier (unsigned)
//  prop      in   2*DATA_WIDTH  accumulate-in value
//  expected  in   2*DATA_WIDTH  reference result for this vector
//  busy      out  1             high in MUL and CMP states
//  done      out  1             1-cycle pulse, verdict valid
//  pass      out  1             last verdict equal (held until next done)
//  fail      out  1             last verdict mismatch (held until next done)
//  mac_out   out  2*DATA_WIDTH  last computed sum (held until next done)
//  pass_cnt  out  CNT_WIDTH     saturating count of passes
//  fail_cnt  out  CNT_WIDTH     saturating count of failures
// BEHAVIOUR
//  - Reset (reset_n=0 at a posedge): state=IDLE. busy, done, pass and fail = 0.
//    mac_out=0, pass_cnt=0, fail_cnt=0. Reset takes priority over everything.
//  - Reset mid-operation aborts the computation. No verdict is issued and no counter changes.
//  - FSM states: IDLE -> MUL -> CMP -> IDLE.
//  - IDLE: on the edge where start=1:
//      capture inp, par, prop and expected into internal registers;
//      set acc<=prop and bit index i<=0; go to MUL.
//    The upstream source may change its outputs afterwards. Only the captured values are used.
//  - MUL: exactly DATA_WIDTH edges, i=0..DATA_WIDTH-1.
//    On each edge: acc <= acc + (par_r[i] ? inp_r<<i : 0).
//    On the last of these edges, go to CMP.
//  - CMP: one edge. On that edge:
//      mac_out<=acc; pass<=(acc==exp_r); fail<=~(acc==exp_r); done<=1;
//      increment the matching counter, saturating at all-ones; go to IDLE.
//  - Latency: start sampled at edge k -> done high during the cycle after edge k+DATA_WIDTH+1.
//    For the default width, done is high in the 10th cycle after the start edge.
//  - done is high for exactly one cycle. pass and fail are never both 1.
//  - Arithmetic: unsigned, modulo 2^(2*DATA_WIDTH). Overflow wraps silently; there is no carry out.
//  - start while busy=1, or while done=1, is ignored. It is not queued.
//  - A start in the same cycle as done is accepted, because the FSM is in IDLE then.
//  - Counters at all-ones stay at all-ones.
// STRUCTURE
//  - Shared package pe_test_pkg:
//      typedef enum logic [1:0] {S_IDLE, S_MUL, S_CMP} chk_state_t;
//      localparam default widths.
//  - Sub-module shift_add_mac holds the datapath: operand regs, acc, bit index.
//    Its controls are load, step, last. The FSM, verdict logic and counters stay in the top.
// TESTING
//  1 start; inp=f1 par=c8 prop=001b exp=bc63
//      -> done 9 edges later; mac_out=bc63; pass=1; pass_cnt=1.
//  2 inp=32 par=17 prop=00d7 exp=0555 -> pass.
//    Then exp=0556 with the same operands -> fail=1, mac_out=0555, fail_cnt=1.
//  3 Wrap: inp=ff par=ff prop=ffff exp=fe00 -> pass (0xfe01+0xffff mod 2^16).
//  4 Operands change the cycle after start; start re-pulsed while busy
//      -> result uses the first capture; only one done is produced.
//  5 reset_n=0 during MUL -> next cycle busy=0, all outputs 0; no done follows.
//    Then 17 consecutive passing vectors -> pass_cnt saturates at f.

Source files
------------

// File: rtl/pe_test_pkg.sv
// Shared definitions for the vector-checker slice.
// Provides the checker FSM state type and the default operand/tally widths
// used by pe_vector_checker and its shift_add_mac datapath.
package pe_test_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_CMP
    } chk_state_t;

endpackage

// File: rtl/shift_add_mac.sv
// Sequential shift-add multiply-accumulate datapath.
// Computes prop + inp*par (unsigned, modulo 2^(2*DATA_WIDTH)) one multiplier
// bit per step.
// Ports:
//   clk   clock
//   load  capture inp/par/prop, acc <= prop, bit index <= 0
//   step  add the partial product selected by the current bit index
//   inp   multiplicand
//   par   multiplier
//   prop  accumulate-in value
//   acc   running accumulator
//   last  current bit index is the final one (step now completes the product)
// The datapath carries no reset: the controlling FSM always issues load
// before any step, so stale contents are never observed.
module shift_add_mac
    import pe_test_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    load,
    input  logic                    step,
    input  logic [DATA_WIDTH-1:0]   inp,
    input  logic [DATA_WIDTH-1:0]   par,
    input  logic [2*DATA_WIDTH-1:0] prop,
    output logic [2*DATA_WIDTH-1:0] acc,
    output logic                    last
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0]   inp_q;
    logic [DATA_WIDTH-1:0]   par_q;
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [2*DATA_WIDTH-1:0] acc_d;
    logic [2*DATA_WIDTH-1:0] addend;
    logic [IDX_W-1:0]        idx_q;

    always_comb begin
        addend = '0;
        if (par_q[idx_q]) begin
            addend = {{DATA_WIDTH{1'b0}}, inp_q} << idx_q;
        end
        // Carry out of the top bit is dropped: the result wraps silently.
        acc_d = acc_q + addend;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            inp_q <= inp;
            par_q <= par;
            acc_q <= prop;
            idx_q <= '0;
        end else if (step) begin
            acc_q <= acc_d;
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    assign acc  = acc_q;
    assign last = (idx_q == IDX_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/pe_vector_checker.sv
// Self-test consumer for a test-vector source.
// On a start pulse in IDLE it captures one vector, computes prop + inp*par with
// the shift_add_mac datapath, compares against expected and reports a verdict
// together with saturating pass/fail tallies.
// Ports:
//   clk       clock
//   reset_n   synchronous active-low reset
//   start     1-cycle request, honoured only in IDLE
//   inp, par  unsigned operands
//   prop      accumulate-in value
//   expected  reference result
//   busy      high while computing or comparing
//   done      1-cycle verdict strobe
//   pass/fail last verdict, held until the next done
//   mac_out   last computed sum, held until the next done
//   pass_cnt  saturating pass tally
//   fail_cnt  saturating fail tally
module pe_vector_checker
    import pe_test_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   inp,
    input  logic [DATA_WIDTH-1:0]   par,
    input  logic [2*DATA_WIDTH-1:0] prop,
    input  logic [2*DATA_WIDTH-1:0] expected,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic [2*DATA_WIDTH-1:0] mac_out,
    output logic [CNT_WIDTH-1:0]    pass_cnt,
    output logic [CNT_WIDTH-1:0]    fail_cnt
);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    chk_state_t state_q, state_d;

    logic                    load;
    logic                    step;
    logic                    last;
    logic                    match;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [2*DATA_WIDTH-1:0] exp_q;
    logic [2*DATA_WIDTH-1:0] mac_q;
    logic                    done_q;
    logic                    pass_q;
    logic                    fail_q;
    logic [CNT_WIDTH-1:0]    pass_cnt_q;
    logic [CNT_WIDTH-1:0]    fail_cnt_q;

    shift_add_mac #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mac (
        .clk  (clk),
        .load (load),
        .step (step),
        .inp  (inp),
        .par  (par),
        .prop (prop),
        .acc  (acc),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign match = (acc == exp_q);

    // Reference value is only meaningful alongside the captured operands.
    always_ff @(posedge clk) begin
        if (load) begin
            exp_q <= expected;
        end
    end

    // Verdict and tallies; a reset during MUL leaves state IDLE before CMP
    // is reached, so an aborted vector never touches these.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            mac_q      <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_CMP) begin
                done_q <= 1'b1;
                mac_q  <= acc;
                pass_q <= match;
                fail_q <= ~match;
                if (match) begin
                    pass_cnt_q <= sat_inc(pass_cnt_q);
                end else begin
                    fail_cnt_q <= sat_inc(fail_cnt_q);
                end
            end
        end
    end

    assign done     = done_q;
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign mac_out  = mac_q;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_pe_vector_checker.sv
// Scoreboard bench for pe_vector_checker: the driver pushes the expected
// verdict of each vector, an independent monitor pops and compares on done.
module tb_pe_vector_checker;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  inp;
    logic [7:0]  par;
    logic [15:0] prop;
    logic [15:0] expected;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic [15:0] mac_out;
    logic [3:0]  pass_cnt;
    logic [3:0]  fail_cnt;

    typedef struct {
        logic [15:0] mac;
        logic        pass;
        logic [3:0]  pc;
        logic [3:0]  fc;
    } sb_t;

    sb_t sb_q[$];

    int vectors;
    int miscompares;
    int checks;
    logic [3:0] m_pc;
    logic [3:0] m_fc;

    pe_vector_checker dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .inp      (inp),
        .par      (par),
        .prop     (prop),
        .expected (expected),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .mac_out  (mac_out),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_t it;
                it = sb_q.pop_front();
                check("mac_out", 32'(mac_out), 32'(it.mac));
                check("pass", 32'(pass), 32'(it.pass));
                check("fail", 32'(fail), 32'(!it.pass));
                check("pass_cnt", 32'(pass_cnt), 32'(it.pc));
                check("fail_cnt", 32'(fail_cnt), 32'(it.fc));
            end
        end
    end

    task automatic expect_vec(input logic [15:0] mac_exp, input logic [15:0] e);
        sb_t it;
        it.mac  = mac_exp;
        it.pass = (mac_exp == e);
        if (it.pass) begin
            if (m_pc != 4'hf) m_pc = m_pc + 4'd1;
        end else begin
            if (m_fc != 4'hf) m_fc = m_fc + 4'd1;
        end
        it.pc = m_pc;
        it.fc = m_fc;
        sb_q.push_back(it);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] c, input logic [15:0] e);
        start    = 1'b1;
        inp      = a;
        par      = b;
        prop     = c;
        expected = e;
    endtask

    // Waits for done after a start edge; returns the number of negedges seen.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            miscompares++;
            $display("FAIL done_timeout: no done within 20 cycles");
        end
    endtask

    task automatic run_vec(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] c, input logic [15:0] e,
                           input logic [15:0] mac_exp);
        int lat;
        expect_vec(mac_exp, e);
        @(negedge clk);
        drive(a, b, c, e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(lat);
        check("latency", 32'(lat), 32'd9);
        vectors++;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        vectors     = 0;
        miscompares = 0;
        checks      = 0;
        m_pc        = 4'd0;
        m_fc        = 4'd0;
        reset_n     = 1'b0;
        start       = 1'b0;
        inp         = 8'h00;
        par         = 8'h00;
        prop        = 16'h0000;
        expected    = 16'h0000;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_mac", 32'(mac_out), 32'd0);
        check("rst_pcnt", 32'(pass_cnt), 32'd0);
        check("rst_fcnt", 32'(fail_cnt), 32'd0);
        reset_n = 1'b1;

        // 0xf1*0xc8 = 0xbc48, + 0x1b
        run_vec(8'hf1, 8'hc8, 16'h001b, 16'hbc63, 16'hbc63);
        // 0x32*0x17 = 0x047e, + 0xd7
        run_vec(8'h32, 8'h17, 16'h00d7, 16'h0555, 16'h0555);
        run_vec(8'h32, 8'h17, 16'h00d7, 16'h0556, 16'h0555);
        // 0xfe01 + 0xffff wraps to 0xfe00
        run_vec(8'hff, 8'hff, 16'hffff, 16'hfe00, 16'hfe00);
        check("held_mac", 32'(mac_out), 32'h0000fe00);
        check("held_pass", 32'(pass), 32'd1);

        // Operands change after capture and start is re-pulsed while busy;
        // 0x12*0x34 = 0x03a8, + 1.
        expect_vec(16'h03a9, 16'h03a9);
        @(negedge clk);
        drive(8'h12, 8'h34, 16'h0001, 16'h03a9);
        @(negedge clk);
        drive(8'hff, 8'hff, 16'hffff, 16'h0000);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("latency_busy_start", 32'(lat), 32'd8);
        vectors++;
        repeat (14) @(negedge clk);
        check("single_done_queue", 32'(sb_q.size()), 32'd0);

        // Reset during MUL aborts the vector.
        @(negedge clk);
        drive(8'h0a, 8'h0b, 16'h0000, 16'h006e);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_pc = 4'd0;
        m_fc = 4'd0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_fail", 32'(fail), 32'd0);
        check("abort_mac", 32'(mac_out), 32'd0);
        check("abort_pcnt", 32'(pass_cnt), 32'd0);
        check("abort_fcnt", 32'(fail_cnt), 32'd0);
        repeat (15) @(negedge clk);
        check("abort_no_done_pcnt", 32'(pass_cnt), 32'd0);

        // 17 passing vectors: i*3 + i = 4*i; tally saturates at f.
        for (int i = 1; i <= 17; i++) begin
            run_vec(8'(i), 8'h03, 16'(i), 16'(4 * i), 16'(4 * i));
        end
        check("sat_pcnt", 32'(pass_cnt), 32'h0000000f);
        check("sat_fcnt", 32'(fail_cnt), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
